// File: rtl/mem_access_seq.sv
// mem_access_seq: load/store sequencer for the multicycle RV32I/RV64I core.
// Accepts one decoded memory request and drives an aligned bus access with
// byte enables and lane-shifted store data. It waits for mem_resp or a
// timeout, then returns an extended load result, an error code and RVFI masks.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_*               request handshake and payload from the control FSM
//   mem_*               memory bus (read/write strobes, address, lanes, data)
//   rsp_valid/rdata/err one-cycle completion pulse with held result
//   rmask, wmask        RVFI byte masks of the completed access
module mem_access_seq #(
   parameter  int XLEN    = 32,
   parameter  int TIMEOUT = 255,
   localparam int NBYTES  = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [NBYTES-1:0] mem_byte_enable,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_resp,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic [NBYTES-1:0] rmask,
   output logic [NBYTES-1:0] wmask
);

   localparam int OFFW = $clog2(NBYTES);
   localparam int CW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                write_q, write_d;
   logic                signed_q, signed_d;
   logic [1:0]          szl_q, szl_d;
   logic [OFFW-1:0]     off_q, off_d;
   logic [NBYTES-1:0]   lanes_q, lanes_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [NBYTES-1:0]   be_q, be_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic [1:0]          err_q, err_d;
   logic [NBYTES-1:0]   rmask_q, rmask_d;
   logic [NBYTES-1:0]   wmask_q, wmask_d;

   // Request decode
   logic [1:0]          req_szl;
   logic                req_legal;
   logic [OFFW-1:0]     req_off;
   logic                req_misal;
   logic [3:0]          req_size4;
   logic [NBYTES-1:0]   req_lanes;
   logic [XLEN-1:0]     req_lane_bits;

   assign req_szl   = req_funct3[1:0];
   assign req_off   = req_addr[OFFW-1:0];
   assign req_size4 = 4'd1 << req_szl;
   // off mod size != 0  <=>  any offset bit below log2(size) is set
   assign req_misal = |(4'(req_off) & (req_size4 - 4'd1));

   always_comb begin
      req_legal = 1'b1;
      case (req_funct3)
         3'b011:        req_legal = (XLEN == 64);
         3'b100,
         3'b101:        req_legal = !req_write;
         3'b110:        req_legal = (XLEN == 64) && !req_write;
         3'b111:        req_legal = 1'b0;
         default:       req_legal = 1'b1;
      endcase
   end

   // Load extraction from the current bus data
   logic [XLEN-1:0] rd_sh;
   logic            rd_sgn;
   logic [XLEN-1:0] ld_ext;

   assign rd_sh = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      rd_sgn = 1'b0;
      case (szl_q)
         2'd0:    rd_sgn = rd_sh[7];
         2'd1:    rd_sgn = rd_sh[15];
         2'd2:    rd_sgn = rd_sh[31];
         default: rd_sgn = 1'b0;
      endcase
   end

   // Per-lane size mask, store-data mask and load extension
   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_lane
         assign req_lanes[gi]           = (4'(gi) < req_size4);
         assign req_lane_bits[gi*8 +: 8] = {8{req_lanes[gi]}};
         assign ld_ext[gi*8 +: 8]       = lanes_q[gi] ? rd_sh[gi*8 +: 8]
                                                      : {8{signed_q & rd_sgn}};
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      signed_d = signed_q;
      szl_d    = szl_q;
      off_d    = off_q;
      lanes_d  = lanes_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      rmask_d  = rmask_q;
      wmask_d  = wmask_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               signed_d = !req_funct3[2];
               szl_d    = req_szl;
               off_d    = req_off;
               lanes_d  = req_lanes;
               addr_d   = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
               be_d     = req_lanes << req_off;
               wdata_d  = (req_wdata & req_lane_bits) << {req_off, 3'b000};
               cnt_d    = '0;
               if (!req_legal || req_misal) begin
                  // Illegal funct3 takes priority over misalignment
                  state_d = RESP;
                  err_d   = req_legal ? 2'b01 : 2'b11;
                  rdata_d = '0;
                  rmask_d = '0;
                  wmask_d = '0;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (mem_resp) begin
               state_d = RESP;
               err_d   = 2'b00;
               rdata_d = write_q ? '0 : ld_ext;
               rmask_d = write_q ? '0 : be_q;
               wmask_d = write_q ? be_q : '0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = RESP;
               err_d   = 2'b10;
               rdata_d = '0;
               rmask_d = '0;
               wmask_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         szl_q    <= '0;
         off_q    <= '0;
         lanes_q  <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= '0;
         rmask_q  <= '0;
         wmask_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         signed_q <= signed_d;
         szl_q    <= szl_d;
         off_q    <= off_d;
         lanes_q  <= lanes_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rmask_q  <= rmask_d;
         wmask_q  <= wmask_d;
      end
   end

   // Bus outputs are gated by state so reset removes them immediately
   logic in_access;
   assign in_access       = (state_q == ACCESS);
   assign req_ready       = (state_q == IDLE);
   assign rsp_valid       = (state_q == RESP);
   assign mem_read        = in_access && !write_q;
   assign mem_write       = in_access && write_q;
   assign mem_addr        = in_access ? addr_q  : '0;
   assign mem_byte_enable = in_access ? be_q    : '0;
   assign mem_wdata       = in_access ? wdata_q : '0;
   assign rsp_rdata       = rdata_q;
   assign rsp_err         = err_q;
   assign rmask           = rmask_q;
   assign wmask           = wmask_q;

endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 32-bit instance, TIMEOUT=4
   logic        a_req_valid, a_req_ready, a_req_write;
   logic [2:0]  a_req_funct3;
   logic [31:0] a_req_addr, a_req_wdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_rsp_rdata;
   logic        a_mem_read, a_mem_write, a_mem_resp, a_rsp_valid;
   logic [3:0]  a_mem_be, a_rmask, a_wmask;
   logic [1:0]  a_rsp_err;

   // 64-bit instance, TIMEOUT=6
   logic        b_req_valid, b_req_ready, b_req_write;
   logic [2:0]  b_req_funct3;
   logic [63:0] b_req_addr, b_req_wdata, b_mem_addr, b_mem_wdata, b_mem_rdata, b_rsp_rdata;
   logic        b_mem_read, b_mem_write, b_mem_resp, b_rsp_valid;
   logic [7:0]  b_mem_be, b_rmask, b_wmask;
   logic [1:0]  b_rsp_err;

   mem_access_seq #(.XLEN(32), .TIMEOUT(4)) u_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
      .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .mem_addr(a_mem_addr), .mem_read(a_mem_read), .mem_write(a_mem_write),
      .mem_byte_enable(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
      .mem_resp(a_mem_resp), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
      .rsp_err(a_rsp_err), .rmask(a_rmask), .wmask(a_wmask)
   );

   mem_access_seq #(.XLEN(64), .TIMEOUT(6)) u_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .mem_addr(b_mem_addr), .mem_read(b_mem_read), .mem_write(b_mem_write),
      .mem_byte_enable(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .mem_resp(b_mem_resp), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err), .rmask(b_rmask), .wmask(b_wmask)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request on the 32-bit instance and take the accept edge
   task automatic req_a(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      a_req_valid  = 1'b1;
      a_req_write  = wr;
      a_req_funct3 = f3;
      a_req_addr   = addr;
      a_req_wdata  = wd;
      tick();
      a_req_valid  = 1'b0;
      a_req_addr   = 32'hFFFF_FFFF;
      a_req_wdata  = 32'h5A5A_5A5A;
   endtask

   task automatic req_b(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd);
      b_req_valid  = 1'b1;
      b_req_write  = wr;
      b_req_funct3 = f3;
      b_req_addr   = addr;
      b_req_wdata  = wd;
      tick();
      b_req_valid  = 1'b0;
      b_req_addr   = '1;
   endtask

   initial begin
      rst = 1'b0;
      a_req_valid = 0; a_req_write = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
      a_mem_rdata = 0; a_mem_resp = 0;
      b_req_valid = 0; b_req_write = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
      b_mem_rdata = 0; b_mem_resp = 0;
      #12;
      chk("reset_req_ready", a_req_ready, 1);
      chk("reset_mem_read",  a_mem_read, 0);
      chk("reset_rsp_valid", a_rsp_valid, 0);
      chk("reset_rsp_err",   a_rsp_err, 0);
      chk("reset_mem_addr",  a_mem_addr, 0);
      rst = 1'b1;
      tick();

      // lb 0x1003, response on first ACCESS cycle
      $display("TXN lb addr=1003");
      req_a(0, 3'b000, 32'h1003, 0);
      chk("lb_mem_read", a_mem_read, 1);
      chk("lb_mem_addr", a_mem_addr, 32'h1000);
      chk("lb_be",       a_mem_be, 4'b1000);
      chk("lb_ready",    a_req_ready, 0);
      a_mem_resp = 1; a_mem_rdata = 32'h80FF_FFFF;
      tick();
      a_mem_resp = 0;
      chk("lb_rsp_valid", a_rsp_valid, 1);
      chk("lb_rdata",     a_rsp_rdata, 32'hFFFF_FF80);
      chk("lb_err",       a_rsp_err, 0);
      chk("lb_rmask",     a_rmask, 4'b1000);
      chk("lb_wmask",     a_wmask, 0);
      chk("lb_mem_read_off", a_mem_read, 0);
      tick();
      chk("lb_rsp_drop", a_rsp_valid, 0);
      chk("lb_rdata_hold", a_rsp_rdata, 32'hFFFF_FF80);

      // sh 0x2002
      $display("TXN sh addr=2002");
      req_a(1, 3'b001, 32'h2002, 32'hDEAD_BEEF);
      chk("sh_mem_write", a_mem_write, 1);
      chk("sh_mem_read",  a_mem_read, 0);
      chk("sh_be",        a_mem_be, 4'b1100);
      chk("sh_wdata",     a_mem_wdata, 32'hBEEF_0000);
      a_mem_resp = 1;
      tick();
      a_mem_resp = 0;
      chk("sh_rsp_valid", a_rsp_valid, 1);
      chk("sh_wmask",     a_wmask, 4'b1100);
      chk("sh_rmask",     a_rmask, 0);
      chk("sh_rdata",     a_rsp_rdata, 0);
      tick();

      // sb 0x5001 lane placement and upper-bit masking
      $display("TXN sb addr=5001");
      req_a(1, 3'b000, 32'h5001, 32'h1234_56AB);
      chk("sb_be",    a_mem_be, 4'b0010);
      chk("sb_wdata", a_mem_wdata, 32'h0000_AB00);
      a_mem_resp = 1;
      tick();
      a_mem_resp = 0;
      chk("sb_wmask", a_wmask, 4'b0010);
      tick();

      // lw misaligned
      $display("TXN lw addr=3001 misaligned");
      req_a(0, 3'b010, 32'h3001, 0);
      chk("mis_mem_read",  a_mem_read, 0);
      chk("mis_rsp_valid", a_rsp_valid, 1);
      chk("mis_err",       a_rsp_err, 2'b01);
      chk("mis_rmask",     a_rmask, 0);
      chk("mis_rdata",     a_rsp_rdata, 0);
      tick();

      // funct3 111 load, funct3 011 store on XLEN=32, lbu-as-store
      $display("TXN load f3=111");
      req_a(0, 3'b111, 32'h1001, 0);
      chk("f3_111_err",  a_rsp_err, 2'b11);
      chk("f3_111_read", a_mem_read, 0);
      tick();
      $display("TXN store f3=011 xlen32");
      req_a(1, 3'b011, 32'h1000, 0);
      chk("sd32_err",   a_rsp_err, 2'b11);
      chk("sd32_write", a_mem_write, 0);
      chk("sd32_valid", a_rsp_valid, 1);
      tick();
      $display("TXN store f3=100");
      req_a(1, 3'b100, 32'h1000, 0);
      chk("sbu_err", a_rsp_err, 2'b11);
      tick();

      // lhu timeout, then a late response
      $display("TXN lhu addr=4002 timeout");
      req_a(0, 3'b101, 32'h4002, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_read_c%0d", i), a_mem_read, 1);
         chk($sformatf("to_novalid_c%0d", i), a_rsp_valid, 0);
         tick();
      end
      chk("to_read_end", a_mem_read, 0);
      chk("to_valid",    a_rsp_valid, 1);
      chk("to_err",      a_rsp_err, 2'b10);
      chk("to_rmask",    a_rmask, 0);
      tick();
      a_mem_resp = 1; a_mem_rdata = 32'h1234_5678;
      tick();
      a_mem_resp = 0;
      chk("late_valid", a_rsp_valid, 0);
      chk("late_ready", a_req_ready, 1);
      chk("late_err",   a_rsp_err, 2'b10);

      // lh with response on the final permitted cycle: response wins
      $display("TXN lh addr=4002 resp at limit");
      req_a(0, 3'b001, 32'h4002, 0);
      tick(); tick(); tick();
      a_mem_resp = 1; a_mem_rdata = 32'h8001_5555;
      tick();
      a_mem_resp = 0;
      chk("edge_valid", a_rsp_valid, 1);
      chk("edge_err",   a_rsp_err, 0);
      chk("edge_rdata", a_rsp_rdata, 32'hFFFF_8001);
      chk("edge_rmask", a_rmask, 4'b1100);
      tick();

      // 64-bit lwu and lw
      $display("TXN lwu64 addr=8004");
      req_b(0, 3'b110, 64'h8004, 0);
      chk("lwu_addr", b_mem_addr, 64'h8000);
      chk("lwu_be",   b_mem_be, 8'hF0);
      b_mem_resp = 1; b_mem_rdata = 64'h8765_4321_0000_0000;
      tick();
      b_mem_resp = 0;
      chk("lwu_rdata", b_rsp_rdata, 64'h0000_0000_8765_4321);
      chk("lwu_rmask", b_rmask, 8'hF0);
      tick();
      $display("TXN lw64 addr=8004");
      req_b(0, 3'b010, 64'h8004, 0);
      b_mem_resp = 1;
      tick();
      b_mem_resp = 0;
      chk("lw64_rdata", b_rsp_rdata, 64'hFFFF_FFFF_8765_4321);
      tick();
      $display("TXN sd64 addr=8008");
      req_b(1, 3'b011, 64'h8008, 64'h1122_3344_5566_7788);
      chk("sd_be",    b_mem_be, 8'hFF);
      chk("sd_wdata", b_mem_wdata, 64'h1122_3344_5566_7788);
      b_mem_resp = 1;
      tick();
      b_mem_resp = 0;
      chk("sd_wmask", b_wmask, 8'hFF);
      tick();

      // reset in the middle of an access
      $display("TXN ld64 addr=8008 reset mid-access");
      req_b(0, 3'b011, 64'h8008, 0);
      chk("rst_pre_read", b_mem_read, 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_read_drop", b_mem_read, 0);
      chk("rst_no_valid",  b_rsp_valid, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("rst_after_valid", b_rsp_valid, 0);
      chk("rst_after_ready", b_req_ready, 1);
      tick();
      chk("rst_after_valid2", b_rsp_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
